// File: rtl/srf02_range_sequencer.sv
// SRF02 range sequencer: command engine -> conversion wait -> read engine -> publish.
// Optional macro SRF02_CONT_MODE_EN adds a free-running period trigger.
module srf02_range_sequencer #(
  parameter int CONV_CYCLES    = 3500000,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int RETRY_MAX      = 3,
  parameter int PERIOD_CYCLES  = 5000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        meas_req,
  input  logic        clr_err,
  output logic        cmd_start,
  input  logic        cmd_done,
  output logic        rd_start,
  input  logic        rd_done,
  input  logic        rd_ack_ok,
  input  logic [15:0] rd_data,
  output logic [15:0] range_cm,
  output logic        range_valid,
  output logic        busy,
  output logic        error,
  output logic [2:0]  state_dbg
);

  // Handshake: *_start is a one-cycle request, issued only while the other
  // engine's done level is high; *_done low means busy, and its return high
  // after having been seen low marks completion.

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CMD_GO   = 3'd1,
    S_CMD_WAIT = 3'd2,
    S_CONV     = 3'd3,
    S_RD_GO    = 3'd4,
    S_RD_WAIT  = 3'd5,
    S_DONE     = 3'd6,
    S_ERROR    = 3'd7
  } state_t;

  localparam int TMO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int CONV_W  = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam int RETRY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0]   TMO_MAX   = '1;
  localparam logic [CONV_W-1:0]  CONV_LAST = CONV_W'(CONV_CYCLES - 1);
  localparam logic [CONV_W-1:0]  CONV_MAX  = '1;
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(RETRY_MAX);
  localparam logic [RETRY_W-1:0] RETRY_SAT = '1;

  state_t             state, state_nx;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [CONV_W-1:0]  conv_cnt;
  logic [RETRY_W-1:0] retry_cnt, retry_nx, retry_inc;
  logic               seen_low;
  logic               error_nx;
  logic               ld_range;
  logic               fail;
  logic               req;
  logic               eng_done;

`ifdef SRF02_CONT_MODE_EN
  localparam int PER_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_CYCLES - 1);

  logic [PER_W-1:0] per_cnt;
  logic             per_tick;
  logic             leave_err;

  assign per_tick  = (per_cnt == PER_LAST);
  assign leave_err = (state == S_ERROR) && (state_nx != S_ERROR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      per_cnt <= '0;
    end else if (leave_err || per_tick) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + 1'b1;
    end
  end

  // Ticks outside IDLE are simply not looked at, so they drop.
  assign req = meas_req | per_tick;
`else
  assign req = meas_req;
`endif

  assign eng_done    = (state == S_RD_WAIT) ? rd_done : cmd_done;
  assign busy        = (state != S_IDLE) && (state != S_ERROR);
  assign range_valid = (state == S_DONE);
  assign state_dbg   = state;
  assign retry_inc   = (retry_cnt == RETRY_SAT) ? retry_cnt : retry_cnt + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      tmo_cnt   <= '0;
      conv_cnt  <= '0;
      retry_cnt <= '0;
      seen_low  <= 1'b0;
      range_cm  <= '0;
      error     <= 1'b0;
    end else begin
      state     <= state_nx;
      retry_cnt <= retry_nx;
      error     <= error_nx;
      if (ld_range) range_cm <= rd_data;

      if (state == S_CMD_WAIT || state == S_RD_WAIT) begin
        if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + 1'b1;
        if (!eng_done) seen_low <= 1'b1;
      end else begin
        tmo_cnt  <= '0;
        seen_low <= 1'b0;
      end

      if (state == S_CONV) begin
        if (conv_cnt != CONV_MAX) conv_cnt <= conv_cnt + 1'b1;
      end else begin
        conv_cnt <= '0;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    cmd_start = 1'b0;
    rd_start  = 1'b0;
    retry_nx  = retry_cnt;
    error_nx  = error & ~clr_err;
    ld_range  = 1'b0;
    fail      = 1'b0;

    case (state)
      S_IDLE: begin
        if (req) state_nx = S_CMD_GO;
      end
      S_CMD_GO: begin
        if (rd_done) begin
          cmd_start = 1'b1;
          state_nx  = S_CMD_WAIT;
        end
      end
      S_CMD_WAIT: begin
        if (seen_low && cmd_done) state_nx = S_CONV;
        else if (tmo_cnt == TMO_LAST) fail = 1'b1;
      end
      S_CONV: begin
        if (conv_cnt == CONV_LAST) state_nx = S_RD_GO;
      end
      S_RD_GO: begin
        if (cmd_done) begin
          rd_start = 1'b1;
          state_nx = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (seen_low && rd_done) begin
          if (rd_ack_ok) begin
            ld_range = 1'b1;
            state_nx = S_DONE;
          end else begin
            fail = 1'b1;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          fail = 1'b1;
        end
      end
      S_DONE: begin
        retry_nx = '0;
        state_nx = S_IDLE;
      end
      S_ERROR: begin
        if (clr_err) begin
          retry_nx = '0;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    // Every retry restarts the full sequence from the command write.
    if (fail) begin
      retry_nx = retry_inc;
      if (retry_inc < RETRY_LIM) begin
        state_nx = S_CMD_GO;
      end else begin
        state_nx = S_ERROR;
        error_nx = 1'b1;
      end
    end
  end

endmodule
